// File: rtl/recurrence_gen.sv
// Two-phase handshake generator for an ORDER-term additive recurrence
// (Fibonacci-style). Each o_req toggle presents h[0] until the synchronized ack matches.
module recurrence_gen #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ORDER       = 2,
  parameter int unsigned INIT_A      = 0,
  parameter int unsigned INIT_B      = 1,
  parameter int unsigned SAT_MODE    = 0,
  parameter int unsigned MAX_TERMS   = 0,
  parameter int unsigned COUNT_WIDTH = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_go,
  input  logic                   i_restart,
  input  logic                   i_ack,
  output logic                   o_req,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic [COUNT_WIDTH-1:0] o_count,
  output logic                   o_done,
  output logic                   o_ovf
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, DONE} state_e;

  state_e                   state_q, state_d;
  logic [DATA_WIDTH-1:0]    hist_q [ORDER];
  logic [DATA_WIDTH-1:0]    hist_d [ORDER];
  logic                     req_q, req_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;
  logic                     ovf_q, ovf_d;
  logic                     pend_q, pend_d;
  logic                     armed_q, armed_d;
  logic [SYNC_STAGES-1:0]   sync_q, sync_d;

  logic                     ack_sync;
  logic [DATA_WIDTH+1:0]    sum_full;
  logic                     sum_ovf;
  logic [DATA_WIDTH-1:0]    sum_res;
  logic [COUNT_WIDTH-1:0]   count_inc;
  logic                     done_hit;
  logic                     do_reload;

  function automatic logic [DATA_WIDTH-1:0] seed(input int unsigned idx);
    if (idx == ORDER - 1)      return DATA_WIDTH'(INIT_B);
    else if (idx == ORDER - 2) return DATA_WIDTH'(INIT_A);
    else                       return '0;
  endfunction

  assign ack_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_ack};
  end

  // Sum carries two guard bits so up to four full-scale terms never alias.
  always_comb begin
    sum_full = '0;
    for (int unsigned i = 0; i < ORDER; i++) begin
      sum_full = sum_full + (DATA_WIDTH+2)'(hist_q[i]);
    end
    sum_ovf = (sum_full > {2'b00, {DATA_WIDTH{1'b1}}});
    if (sum_ovf && (SAT_MODE != 0)) sum_res = '1;
    else                            sum_res = sum_full[DATA_WIDTH-1:0];
  end

  assign count_inc = count_q + COUNT_WIDTH'(1);
  assign done_hit  = (MAX_TERMS != 0) && (count_inc == COUNT_WIDTH'(MAX_TERMS));

  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    req_d     = req_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    pend_d    = pend_q;
    armed_d   = 1'b1;
    do_reload = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_restart) begin
          do_reload = 1'b1;
        end else if (i_go && armed_q) begin
          req_d   = ~req_q;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (i_restart) pend_d = 1'b1;
        if (ack_sync == req_q) begin
          if (pend_q || i_restart) begin
            do_reload = 1'b1;
          end else begin
            for (int unsigned i = 0; i < ORDER - 1; i++) begin
              hist_d[i] = hist_q[i+1];
            end
            hist_d[ORDER-1] = sum_res;
            ovf_d   = ovf_q | sum_ovf;
            count_d = count_inc;
            state_d = done_hit ? DONE : IDLE;
          end
        end
      end
      DONE: begin
        if (i_restart) do_reload = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Restart leaves the request phase alone so the consumer stays in step.
    if (do_reload) begin
      for (int unsigned i = 0; i < ORDER; i++) begin
        hist_d[i] = seed(i);
      end
      count_d = '0;
      ovf_d   = 1'b0;
      pend_d  = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      for (int unsigned i = 0; i < ORDER; i++) begin
        hist_q[i] <= seed(i);
      end
      req_q   <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      pend_q  <= 1'b0;
      armed_q <= 1'b0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      req_q   <= req_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
      armed_q <= armed_d;
      sync_q  <= sync_d;
    end
  end

  assign o_req   = req_q;
  assign o_data  = hist_q[0];
  assign o_count = count_q;
  assign o_done  = (state_q == DONE);
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_recurrence_gen.sv
// Directed bench for recurrence_gen: five parameterisations driven through
// the two-phase handshake with hand-computed term sequences.
module tb_recurrence_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  go, restart, ack;
  logic [4:0]  req_a, done_a, ovf_a;
  logic [4:0]  exp_req;
  logic [15:0] cnt_a [5];
  logic [15:0] data_a [5];
  logic [15:0] d0, d3, d4;
  logic [7:0]  d1, d2;

  int vectors;
  int errs;

  always #5 clk = ~clk;

  assign data_a[0] = d0;
  assign data_a[1] = {8'h00, d1};
  assign data_a[2] = {8'h00, d2};
  assign data_a[3] = d3;
  assign data_a[4] = d4;

  recurrence_gen u_def (
    .i_clk(clk), .i_rst(rst), .i_go(go[0]), .i_restart(restart[0]), .i_ack(ack[0]),
    .o_req(req_a[0]), .o_data(d0), .o_count(cnt_a[0]), .o_done(done_a[0]), .o_ovf(ovf_a[0])
  );

  recurrence_gen #(.DATA_WIDTH(8), .SAT_MODE(1)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_go(go[1]), .i_restart(restart[1]), .i_ack(ack[1]),
    .o_req(req_a[1]), .o_data(d1), .o_count(cnt_a[1]), .o_done(done_a[1]), .o_ovf(ovf_a[1])
  );

  recurrence_gen #(.DATA_WIDTH(8), .SAT_MODE(0)) u_wrap (
    .i_clk(clk), .i_rst(rst), .i_go(go[2]), .i_restart(restart[2]), .i_ack(ack[2]),
    .o_req(req_a[2]), .o_data(d2), .o_count(cnt_a[2]), .o_done(done_a[2]), .o_ovf(ovf_a[2])
  );

  recurrence_gen #(.ORDER(3), .INIT_A(0), .INIT_B(1)) u_ord3 (
    .i_clk(clk), .i_rst(rst), .i_go(go[3]), .i_restart(restart[3]), .i_ack(ack[3]),
    .o_req(req_a[3]), .o_data(d3), .o_count(cnt_a[3]), .o_done(done_a[3]), .o_ovf(ovf_a[3])
  );

  recurrence_gen #(.MAX_TERMS(5)) u_max (
    .i_clk(clk), .i_rst(rst), .i_go(go[4]), .i_restart(restart[4]), .i_ack(ack[4]),
    .o_req(req_a[4]), .o_data(d4), .o_count(cnt_a[4]), .o_done(done_a[4]), .o_ovf(ovf_a[4])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the next request toggle, then check the presented term.
  task automatic wait_req(input int k, input logic [15:0] exp_d, input string tag);
    exp_req[k] = ~exp_req[k];
    for (int n = 0; n < 40 && req_a[k] !== exp_req[k]; n++) begin
      @(posedge clk); #1;
    end
    check({tag, "_req"}, 32'(req_a[k]), 32'(exp_req[k]));
    check({tag, "_data"}, 32'(data_a[k]), 32'(exp_d));
  endtask

  // Ack three cycles after the toggle; completion lands on the third edge after.
  task automatic ack_done(input int k, input logic [15:0] exp_cnt, input string tag);
    repeat (3) @(posedge clk);
    #1 ack[k] = ~ack[k];
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_cnt"}, 32'(cnt_a[k]), 32'(exp_cnt));
    check({tag, "_hold"}, 32'(req_a[k]), 32'(exp_req[k]));
  endtask

  initial begin
    logic [15:0] fib  [8]  = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13};
    logic [15:0] sat  [16] = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13,
                               16'd21, 16'd34, 16'd55, 16'd89, 16'd144, 16'd233, 16'd255, 16'd255};
    logic [15:0] wrp  [15] = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13,
                               16'd21, 16'd34, 16'd55, 16'd89, 16'd144, 16'd233, 16'd121};
    logic [15:0] trib [8]  = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd2, 16'd4, 16'd7, 16'd13};

    vectors = 0;
    errs    = 0;
    rst     = 1'b1;
    go      = '0;
    restart = '0;
    ack     = '0;
    exp_req = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req",   32'(req_a),  32'h0);
    check("rst_data0", 32'(data_a[0]), 32'h0);
    check("rst_data3", 32'(data_a[3]), 32'h0);
    check("rst_cnt0",  32'(cnt_a[0]), 32'h0);
    check("rst_done",  32'(done_a), 32'h0);
    check("rst_ovf",   32'(ovf_a),  32'h0);
    rst = 1'b0;

    go[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_req(0, fib[i], $sformatf("fib_t%0d", i));
      ack_done(0, 16'(i + 1), $sformatf("fib_t%0d", i));
    end

    go[1] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wait_req(1, sat[i], $sformatf("sat_t%0d", i));
      if (i == 14) check("sat_ovf_set", 32'(ovf_a[1]), 32'h1);
      ack_done(1, 16'(i + 1), $sformatf("sat_t%0d", i));
      if (i == 11) check("sat_ovf_clear", 32'(ovf_a[1]), 32'h0);
    end
    go[1] = 1'b0;

    go[2] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      wait_req(2, wrp[i], $sformatf("wrap_t%0d", i));
      if (i == 14) check("wrap_ovf", 32'(ovf_a[2]), 32'h1);
      ack_done(2, 16'(i + 1), $sformatf("wrap_t%0d", i));
    end
    go[2] = 1'b0;

    go[3] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_req(3, trib[i], $sformatf("ord3_t%0d", i));
      ack_done(3, 16'(i + 1), $sformatf("ord3_t%0d", i));
    end
    go[3] = 1'b0;

    go[4] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_req(4, fib[i], $sformatf("max_t%0d", i));
      ack_done(4, 16'(i + 1), $sformatf("max_t%0d", i));
    end
    check("max_done", 32'(done_a[4]), 32'h1);
    check("max_cnt",  32'(cnt_a[4]),  32'd5);
    repeat (10) @(posedge clk);
    #1;
    check("max_no_toggle", 32'(req_a[4]), 32'(exp_req[4]));
    check("max_done_hold", 32'(done_a[4]), 32'h1);
    restart[4] = 1'b1;
    @(posedge clk);
    #1 restart[4] = 1'b0;
    check("max_rs_done", 32'(done_a[4]), 32'h0);
    check("max_rs_cnt",  32'(cnt_a[4]),  32'h0);
    check("max_rs_data", 32'(data_a[4]), 32'h0);
    wait_req(4, 16'd0, "max_rs_t0");
    ack_done(4, 16'd1, "max_rs_t0");
    go[4] = 1'b0;

    // u_def has been parked in WAIT_ACK on term 8 (21) since its loop ended.
    wait_req(0, 16'd21, "def_t8");
    go[0] = 1'b0;
    restart[0] = 1'b1;
    @(posedge clk);
    #1 restart[0] = 1'b0;
    ack_done(0, 16'd0, "pend_rs");
    check("pend_rs_data", 32'(data_a[0]), 32'h0);
    repeat (10) @(posedge clk);
    #1;
    check("pend_rs_idle", 32'(req_a[0]), 32'(exp_req[0]));
    go[0] = 1'b1;
    wait_req(0, 16'd0, "pend_t0");
    ack_done(0, 16'd1, "pend_t0");
    wait_req(0, 16'd1, "pend_t1");

    #3 rst = 1'b1;
    ack     = '0;
    exp_req = '0;
    #1;
    check("async_rst_req",  32'(req_a[0]),  32'h0);
    check("async_rst_data", 32'(data_a[0]), 32'h0);
    check("async_rst_cnt",  32'(cnt_a[0]),  32'h0);
    check("async_rst_ovf",  32'(ovf_a[1]),  32'h0);

    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("rel_first_edge", 32'(req_a[0]), 32'h0);
    wait_req(0, 16'd0, "rel_t0");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
